afe_spi_sequencer: RTL
======================

AFE_SPI_SEQUENCER -- requirements
Module: afe_spi_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4, meaning clk cycles per SCLK half-period (legal range 1..255).
REQ-002 SHALL have parameter CS_GAP, default 8, meaning minimum clk cycles cs_n stays high between commands (legal range 1..255).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  single-cycle request to run the ROM command sequence.
REQ-006 SHALL have port rom_address  output  8  address to the command ROM.
REQ-007 SHALL have port rom_command  input  24  ROM data; valid one clk after rom_address changes (registered ROM).
REQ-008 SHALL have port busy  output  1  high from the cycle after an accepted start until the sequence ends.
REQ-009 SHALL have port done  output  1  sticky end-of-sequence flag.
REQ-010 SHALL have port error  output  1  sticky reserved-opcode flag (see Configuration).
REQ-011 SHALL have port cmd_count  output  8  number of commands fully shifted in the current run.
REQ-012 SHALL have ports spi_cs_n, spi_sclk, spi_mosi  output  1 each  SPI mode 0 bus to the AFE.

Function
REQ-013 SHALL implement states IDLE, FETCH, WAIT, DECODE, SHIFT, GAP, FINISH, ERR.
REQ-014 IDLE + start=1 -> FETCH; rom_address<=0, cmd_count<=0, done<=0, error<=0, busy<=1.
REQ-015 FETCH lasts 1 cycle (ROM samples address); WAIT lasts 1 cycle; at end of WAIT rom_command SHALL be captured into a 24-bit holding register; then DECODE.
REQ-016 DECODE: bits[23:20]=0001 -> SHIFT; 0000 -> FINISH; any other value -> per REQ-029/030.
REQ-017 SHIFT: spi_cs_n low for the whole 20-bit frame; bits[19:0] sent MSB first.
REQ-018 spi_mosi SHALL be valid CLK_DIV clk cycles before each SCLK rising edge; it changes only on SCLK falling edges or at cs_n assertion.
REQ-019 spi_sclk idles low; exactly 20 rising edges per frame; each high and low phase lasts CLK_DIV clk cycles.
REQ-020 After the 20th falling edge, spi_cs_n SHALL rise after a further CLK_DIV cycles; cmd_count increments by 1 in that cycle; state -> GAP.
REQ-021 GAP: spi_cs_n held high for CS_GAP cycles; then, if rom_address=255 -> FINISH, else rom_address increments by 1 and state -> FETCH (no wrap to 0).
REQ-022 FINISH: busy<=0, done<=1, -> IDLE; done stays high until the next accepted start.
REQ-023 start SHALL be ignored in every state except IDLE.
REQ-024 Command-to-command latency: GAP end to next cs_n fall SHALL be exactly 3 clk cycles (FETCH, WAIT, DECODE).
REQ-025 spi_cs_n SHALL never fall outside SHIFT nor rise mid-frame, except on reset.

Reset
REQ-026 reset_n low SHALL force, asynchronously: state IDLE, rom_address=0, busy=0, done=0, error=0, cmd_count=0, spi_cs_n=1, spi_sclk=0, spi_mosi=0.
REQ-027 Reset mid-frame SHALL abort the frame immediately (cs_n high same cycle reset asserts); no resume after release.
REQ-028 After reset release the block SHALL remain in IDLE until start.

Configuration
REQ-029 With macro AFE_SEQ_RESERVED_ERR_EN defined: reserved opcode -> ERR; ERR sets error=1, busy=0, done=0, -> IDLE; error sticky until next accepted start.
REQ-030 Without AFE_SEQ_RESERVED_ERR_EN: reserved opcode treated as 0000 (-> FINISH, done=1); error output tied to 0.

Verification
REQ-031 ROM {0x112345, 0x1ABCDE, 0x000000}, CLK_DIV=4, start -> two frames MOSI 0x12345 then 0xABCDE, 20 SCLK rising edges each, cmd_count=2, done=1, busy=0.
REQ-032 ROM[0]=0x000000, start -> no cs_n activity, done=1 within 4 cycles, cmd_count=0.
REQ-033 ROM[1]=0x5FFFFF, macro defined -> one frame sent, error=1, done=0; macro undefined -> error=0, done=1.
REQ-034 reset_n low at SCLK edge 10 of first frame -> cs_n=1, sclk=0, all outputs at reset values that cycle; start pulses while busy ignored.
REQ-035 All 256 entries opcode 0001, CLK_DIV=1, CS_GAP=1 -> 256 frames, rom_address stops at 255, done=1, cmd_count=0 (8-bit wrap of 256).

Source files
------------

// File: rtl/afe_spi_sequencer.sv
// Walks a registered command ROM and shifts each 20-bit payload to the AFE (SPI mode 0).
// Define AFE_SEQ_RESERVED_ERR_EN to flag reserved opcodes on error instead of ending quietly.
module afe_spi_sequencer #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  output logic [7:0]  rom_address,
  input  logic [23:0] rom_command,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  cmd_count,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi
);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, DECODE, SHIFT, GAP, FINISH, ERR
  } state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] GAP_LAST = 8'(CS_GAP - 1);
  localparam logic [5:0] PH_LAST  = 6'd40;

`ifdef AFE_SEQ_RESERVED_ERR_EN
  localparam state_t RSV_NEXT = ERR;
  logic err_q;
  assign error = err_q;
`else
  localparam state_t RSV_NEXT = FINISH;
  assign error = 1'b0;
`endif

  state_t      state;
  logic [23:0] cmd_q;
  logic [19:0] shreg;
  logic [7:0]  div_cnt;
  logic [7:0]  gap_cnt;
  logic [5:0]  phase;
  logic [3:0]  op;

  assign op = cmd_q[23:20];

  // Frame = 41 half-phases: 20 low/high pairs plus a trailing low before cs_n rises.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rom_address <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
`ifdef AFE_SEQ_RESERVED_ERR_EN
      err_q       <= 1'b0;
`endif
      cmd_count   <= '0;
      spi_cs_n    <= 1'b1;
      spi_sclk    <= 1'b0;
      spi_mosi    <= 1'b0;
      cmd_q       <= '0;
      shreg       <= '0;
      div_cnt     <= '0;
      gap_cnt     <= '0;
      phase       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= FETCH;
            rom_address <= '0;
            cmd_count   <= '0;
            done        <= 1'b0;
`ifdef AFE_SEQ_RESERVED_ERR_EN
            err_q       <= 1'b0;
`endif
            busy        <= 1'b1;
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          cmd_q <= rom_command;
          state <= DECODE;
        end
        DECODE: begin
          unique case (1'b1)
            (op == 4'h1): begin
              state    <= SHIFT;
              spi_cs_n <= 1'b0;
              spi_sclk <= 1'b0;
              spi_mosi <= cmd_q[19];
              shreg    <= {cmd_q[18:0], 1'b0};
              div_cnt  <= '0;
              phase    <= '0;
            end
            (op == 4'h0): state <= FINISH;
            default:      state <= RSV_NEXT;
          endcase
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (phase == PH_LAST) begin
              spi_cs_n  <= 1'b1;
              cmd_count <= cmd_count + 8'd1;
              gap_cnt   <= '0;
              state     <= GAP;
            end else begin
              phase    <= phase + 6'd1;
              spi_sclk <= ~spi_sclk;
              if (spi_sclk) begin
                spi_mosi <= shreg[19];
                shreg    <= {shreg[18:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 8'd1;
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (rom_address == 8'hFF) begin
              state <= FINISH;
            end else begin
              rom_address <= rom_address + 8'd1;
              state       <= FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          busy  <= 1'b0;
          done  <= 1'b0;
`ifdef AFE_SEQ_RESERVED_ERR_EN
          err_q <= 1'b1;
`endif
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
